// File: rtl/fpu_arb_pkg.sv
// Shared types for the FP add/sub arbiter: owner and opcode encodings,
// the tag-slot payload carried beside the FP pipe, and operand formatting.
package fpu_arb_pkg;

    localparam int unsigned TAG_W_DFLT = 5;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic                  vld;
        owner_e                owner;
        logic [TAG_W_DFLT-1:0] tag;
    } issue_tag_t;

    // The attached unit computes x1 - x2, so an add is issued with x2 negated.
    function automatic logic [31:0] fmt_x2(input op_e op, input logic [31:0] x2);
        return {x2[31] ^ (op == OP_ADD), x2[30:0]};
    endfunction

endpackage

// File: rtl/fpu_tag_delay.sv
// Fixed-depth shift register carrying {vld, owner, tag} alongside the FP pipe.
// Ports: sys_clk, rstn (async active-low), din (slot loaded this cycle),
//        dout (oldest slot, aligned with the FP unit's result).
module fpu_tag_delay
    import fpu_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       sys_clk,
    input  logic       rstn,
    input  issue_tag_t din,
    output issue_tag_t dout
);

    issue_tag_t sr [DEPTH];

    // Shifts every cycle; idle cycles insert invalid slots.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Shares one fixed-latency FP subtract pipe between requesters A and B.
// Round-robin issue, add implemented by negating x2, tags ride a delay line
// and results are routed back to their owner.
// Ports: sys_clk, rstn (async active-low);
//        a_/b_ valid, ready (combinational), op, x1, x2, tag  - request side;
//        a_/b_ rsp_valid, rsp_y, rsp_tag                      - response side;
//        pipe_valid, pipe_x1, pipe_x2 / pipe_out_valid, pipe_y - FP unit;
//        err - sticky result/slot sequencing error.
module fpu_addsub_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int unsigned LAT          = 3,
    parameter int unsigned TAG_W        = TAG_W_DFLT,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic             sys_clk,
    input  logic             rstn,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic             a_op,
    input  logic [31:0]      a_x1,
    input  logic [31:0]      a_x2,
    input  logic [TAG_W-1:0] a_tag,
    output logic             a_rsp_valid,
    output logic [31:0]      a_rsp_y,
    output logic [TAG_W-1:0] a_rsp_tag,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic             b_op,
    input  logic [31:0]      b_x1,
    input  logic [31:0]      b_x2,
    input  logic [TAG_W-1:0] b_tag,
    output logic             b_rsp_valid,
    output logic [31:0]      b_rsp_y,
    output logic [TAG_W-1:0] b_rsp_tag,
    output logic             pipe_valid,
    output logic [31:0]      pipe_x1,
    output logic [31:0]      pipe_x2,
    input  logic             pipe_out_valid,
    input  logic [31:0]      pipe_y,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned DEPTH = LAT + 1;

    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    owner_e           last_grant;
    logic             elig_a;
    logic             elig_b;
    logic             accept;
    logic             seq_err;
    logic             dec_a;
    logic             dec_b;
    issue_tag_t       slot_in;
    issue_tag_t       slot_out;

    // Arbitration: a lone eligible requester wins; on contention the one not
    // granted last time wins.
    assign elig_a  = a_valid && (cnt_a < CNT_W'(MAX_INFLIGHT));
    assign elig_b  = b_valid && (cnt_b < CNT_W'(MAX_INFLIGHT));
    assign a_ready = elig_a && (!elig_b || (last_grant == OWN_B));
    assign b_ready = elig_b && (!elig_a || (last_grant == OWN_A));
    assign accept  = a_ready || b_ready;

    // Slot entered into the delay line in step with pipe_valid.
    always_comb begin
        slot_in       = '0;
        slot_in.vld   = accept;
        slot_in.owner = b_ready ? OWN_B : OWN_A;
        slot_in.tag   = b_ready ? TAG_W_DFLT'(b_tag) : TAG_W_DFLT'(a_tag);
    end

    fpu_tag_delay #(
        .DEPTH (DEPTH)
    ) u_tag_delay (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .din     (slot_in),
        .dout    (slot_out)
    );

    // Result and slot must arrive together; any disagreement is a sequencing
    // error and suppresses the response and counter decrement.
    assign seq_err = pipe_out_valid != slot_out.vld;
    assign dec_a   = pipe_out_valid && slot_out.vld && (slot_out.owner == OWN_A);
    assign dec_b   = pipe_out_valid && slot_out.vld && (slot_out.owner == OWN_B);

    // Issue registers, grant pointer and sticky error.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            pipe_valid <= 1'b0;
            pipe_x1    <= '0;
            pipe_x2    <= '0;
            last_grant <= OWN_B;
            err        <= 1'b0;
        end else begin
            pipe_valid <= accept;
            if (accept) begin
                pipe_x1    <= b_ready ? b_x1 : a_x1;
                pipe_x2    <= b_ready ? fmt_x2(op_e'(b_op), b_x2) : fmt_x2(op_e'(a_op), a_x2);
                last_grant <= b_ready ? OWN_B : OWN_A;
            end
            if (seq_err) begin
                err <= 1'b1;
            end
        end
    end

    // Outstanding counters; simultaneous inc and dec cancel.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            case ({a_ready, dec_a})
                2'b10:   cnt_a <= cnt_a + CNT_W'(1);
                2'b01:   cnt_a <= cnt_a - CNT_W'(1);
                default: cnt_a <= cnt_a;
            endcase
            case ({b_ready, dec_b})
                2'b10:   cnt_b <= cnt_b + CNT_W'(1);
                2'b01:   cnt_b <= cnt_b - CNT_W'(1);
                default: cnt_b <= cnt_b;
            endcase
        end
    end

    // Response registers: valid pulses one cycle, data holds between results.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            a_rsp_valid <= 1'b0;
            a_rsp_y     <= '0;
            a_rsp_tag   <= '0;
            b_rsp_valid <= 1'b0;
            b_rsp_y     <= '0;
            b_rsp_tag   <= '0;
        end else begin
            a_rsp_valid <= dec_a;
            b_rsp_valid <= dec_b;
            if (dec_a) begin
                a_rsp_y   <= pipe_y;
                a_rsp_tag <= TAG_W'(slot_out.tag);
            end
            if (dec_b) begin
                b_rsp_y   <= pipe_y;
                b_rsp_tag <= TAG_W'(slot_out.tag);
            end
        end
    end

endmodule
